// File: rtl/exponent_vector_seq_pkg.sv
// Shared types and helpers for the time-multiplexed exponent vector controller.
// Holds the controller state encoding, default timing constants and the index-width helper.
package exp_vec_pkg;

    typedef enum logic [2:0] {
        FLUSH = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int DEF_LAT     = 8;
    localparam int DEF_TIMEOUT = 64;

    // Counters that must also hold the terminal value n need $clog2(n+1) bits.
    function automatic int idx_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/exponent_vector_seq_if.sv
// Bundle of the vector-side handshakes and the shared exponent core strobes.
interface exponent_vector_seq_if #(
    parameter int BITS = 16,
    parameter int N    = 3
);
    // Handshake rule for in_* and out_*: a transfer happens on a rising clk edge
    // where valid && ready; once raised, valid and its data hold until that edge,
    // and valid never waits on ready. The core side has no ready: strobes are final.
    logic                      in_valid;
    logic                      in_ready;
    logic [N-1:0][BITS-1:0]    a;
    logic                      out_valid;
    logic                      out_ready;
    logic [N-1:0][BITS-1:0]    c;
    logic                      ex_in_valid;
    logic [BITS-1:0]           ex_a;
    logic                      ex_out_valid;
    logic [BITS-1:0]           ex_c;

    modport slave (
        input  in_valid, a, out_ready, ex_out_valid, ex_c,
        output in_ready, out_valid, c, ex_in_valid, ex_a
    );

    modport master (
        output in_valid, a, out_ready, ex_out_valid, ex_c,
        input  in_ready, out_valid, c, ex_in_valid, ex_a
    );

endinterface

// File: rtl/exponent_vector_seq_collector.sv
// In-order result collector: writes core results into res[ret_idx] while enabled,
// flags completion after the Nth capture, and exposes the next-state register file.
module exp_result_collector
    import exp_vec_pkg::*;
#(
    parameter int BITS = 16,
    parameter int N    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic                   ex_out_valid,
    input  logic [BITS-1:0]        ex_c,
    output logic [N-1:0][BITS-1:0] res_d,
    output logic                   last,
    output logic                   full
);

    localparam int IW = idx_w(N);

    logic [IW-1:0]          ret_idx;
    logic [N-1:0][BITS-1:0] res;
    logic                   capture;

    assign capture = en && ex_out_valid && !full;
    assign last    = capture && (ret_idx == IW'(N - 1));

    // res_d lets the parent register the vector on the same edge the last result lands.
    always_comb begin
        res_d = res;
        if (capture) begin
            res_d[ret_idx] = ex_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ret_idx <= '0;
            res     <= '0;
            full    <= 1'b0;
        end else begin
            res <= res_d;
            if (capture) begin
                ret_idx <= ret_idx + IW'(1);
            end
            if (last) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/exponent_vector_seq.sv
// Time-multiplexed N-element exponent controller feeding one shared pipelined core.
// Optional watchdog on the WAIT state is enabled with macro EXPV_TIMEOUT_EN.
module exponent_vector_seq
    import exp_vec_pkg::*;
#(
    parameter int BITS      = 16,
    parameter     PRECISION = "HALF",
    parameter int N         = 3,
    parameter int LAT       = DEF_LAT,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    exponent_vector_seq_if.slave bus,
    output logic                 busy,
    output logic                 err,
    output logic [2:0]           dbg_state
);

    localparam int IW = idx_w(N);
    localparam int FW = idx_w(LAT);

    localparam logic [2:0] ST_FLUSH = FLUSH;
    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_ISSUE = ISSUE;
    localparam logic [2:0] ST_WAIT  = WAIT;
    localparam logic [2:0] ST_DONE  = DONE;

    // Degenerate configurations elaborate to nothing useful; keep them visible by name.
    if (N < 1 || LAT < 1 || TIMEOUT < 1 || (PRECISION == "HALF" && BITS != 16)) begin : g_bad_cfg
    end

    logic [2:0]             state;
    logic [IW-1:0]          issue_idx;
    logic [FW-1:0]          flush_cnt;
    logic [N-1:0][BITS-1:0] op;
    logic [N-1:0][BITS-1:0] c_q;
    logic [N-1:0][BITS-1:0] res_d;
    logic                   coll_last;
    logic                   coll_full;
    logic                   complete;
    logic                   last_issue;
    logic                   wd_expire;

    assign bus.in_ready    = (state == ST_IDLE);
    assign bus.out_valid   = (state == ST_DONE);
    assign bus.ex_in_valid = (state == ST_ISSUE);
    assign bus.ex_a        = (state == ST_ISSUE) ? op[issue_idx] : '0;
    assign bus.c           = c_q;
    assign busy            = (state != ST_IDLE);
    assign dbg_state       = state;

    assign last_issue = (state == ST_ISSUE) && (issue_idx == IW'(N - 1));
    assign complete   = coll_full || coll_last;

    exp_result_collector #(
        .BITS (BITS),
        .N    (N)
    ) u_collector (
        .clk          (clk),
        .rst          (rst),
        .clear        (bus.in_valid && bus.in_ready),
        .en           ((state == ST_ISSUE) || (state == ST_WAIT)),
        .ex_out_valid (bus.ex_out_valid),
        .ex_c         (bus.ex_c),
        .res_d        (res_d),
        .last         (coll_last),
        .full         (coll_full)
    );

`ifdef EXPV_TIMEOUT_EN
    localparam int WW = idx_w(TIMEOUT);

    logic [WW-1:0] wd_cnt;
    logic          err_q;

    assign wd_expire = (state == ST_WAIT) && (wd_cnt == WW'(TIMEOUT - 1)) && !complete;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (wd_expire) begin
            err_q <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            issue_idx <= '0;
            op        <= '0;
            c_q       <= '0;
        end else begin
            case (state)
                // The core has no reset; anything it emits here is stale and ignored.
                ST_FLUSH: begin
                    if (flush_cnt == FW'(LAT - 1)) begin
                        flush_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op        <= bus.a;
                        issue_idx <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    issue_idx <= issue_idx + IW'(1);
                    if (last_issue) begin
                        if (complete) begin
                            c_q   <= res_d;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (complete || wd_expire) begin
                        c_q   <= res_d;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_FLUSH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exponent_vector_seq.sv
// Randomized bench for exponent_vector_seq with a variable-latency core model.
// Define EXPV_TIMEOUT_EN to also exercise the watchdog path.
module tb_exponent_vector_seq;

    localparam int BITS = 16;
    localparam int N    = 3;
    localparam int LAT  = 8;
`ifdef EXPV_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 64;
`endif

    logic       clk;
    logic       rst;
    logic       busy;
    logic       err;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [BITS-1:0] exp_q[$];

    exponent_vector_seq_if #(.BITS(BITS), .N(N)) bus ();

    exponent_vector_seq #(
        .BITS      (BITS),
        .PRECISION ("HALF"),
        .N         (N),
        .LAT       (LAT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within bound");
        $fatal(1, "global timeout");
    end

    // ---------------- core model ----------------
    // Result of an operand sampled at edge t appears after edge t+lat-1 for one cycle.
    function automatic logic [BITS-1:0] core_f(input logic [BITS-1:0] x);
        return x * 16'd3 + 16'h1234;
    endfunction

    int              lat   = 4;
    logic            drop3 = 1'b0;
    logic            inj_v = 1'b0;
    int              iss_cnt = 0;
    logic            pv [16] = '{default: 1'b0};
    logic [BITS-1:0] pd [16] = '{default: '0};

    always @(posedge clk) begin
        for (int i = 15; i > 0; i--) begin
            pv[i] <= (i < lat) ? pv[i-1] : 1'b0;
            pd[i] <= pd[i-1];
        end
        pv[0] <= bus.ex_in_valid && !(drop3 && iss_cnt == 2);
        pd[0] <= core_f(bus.ex_a);
        if (bus.in_valid && bus.in_ready) iss_cnt <= 0;
        else if (bus.ex_in_valid)         iss_cnt <= iss_cnt + 1;
    end

    assign bus.ex_out_valid = pv[lat-1] | inj_v;
    assign bus.ex_c         = inj_v ? 16'hdead : pd[lat-1];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic wait_idle();
        int w = 0;
        while (!bus.in_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("idle_reached", bus.in_ready, 1'b1);
    endtask

    task automatic run_vec(input logic [N-1:0][BITS-1:0] v, input int l,
                           input int hold, input bit expect_err);
        int cyc;
        int want_lat;
        logic [N-1:0][BITS-1:0] snap;
        lat = l;
        wait_idle();
        bus.a        = v;
        bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++)
            exp_q.push_back((drop3 && i == 2) ? '0 : core_f(v[i]));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        cyc = 1;
        while (!bus.out_valid && cyc < 300) begin
            if (cyc <= N) begin
                check($sformatf("ex_in_valid_c%0d", cyc), bus.ex_in_valid, 1'b1);
                check($sformatf("ex_a_c%0d", cyc), bus.ex_a, v[cyc-1]);
            end else if (cyc == N + 1) begin
                check("ex_in_valid_off", bus.ex_in_valid, 1'b0);
            end
            cyc++;
            @(negedge clk);
        end
        want_lat = expect_err ? (N + TIMEOUT + 1) : (N + l + 1);
        check("out_latency", cyc, want_lat);
        check("err", err, expect_err);
        for (int i = 0; i < N; i++) begin
            if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
            else check($sformatf("c%0d", i), bus.c[i], exp_q.pop_front());
        end
        snap = bus.c;
        for (int h = 0; h < hold; h++) begin
            check("hold_c", bus.c, snap);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_out_valid", bus.out_valid, 1'b1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_hs_in_ready", bus.in_ready, 1'b1);
        check("post_hs_out_valid", bus.out_valid, 1'b0);
    endtask

    function automatic logic [N-1:0][BITS-1:0] rand_vec();
        logic [N-1:0][BITS-1:0] v;
        for (int i = 0; i < N; i++) v[i] = BITS'($urandom);
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0][BITS-1:0] v;
        int cnt;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_ex_in_valid", bus.ex_in_valid, 1'b0);
        check("rst_ex_a", bus.ex_a, 0);
        check("rst_c", bus.c, 0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_state", dbg_state, 3'd0);

        // Flush window with stale core strobes on the first three cycles.
        rst = 1'b0;
        cnt = 0;
        while (!bus.in_ready && cnt < 100) begin
            cnt++;
            inj_v = (cnt <= 3);
            @(negedge clk);
        end
        inj_v = 1'b0;
        check("flush_len", cnt, LAT);
        check("flush_c", bus.c, 0);
        check("idle_busy", busy, 1'b0);

        // Basic vector {0x3C00, 0x0000, 0x4000}, latency 4.
        v[0] = 16'h3C00; v[1] = 16'h0000; v[2] = 16'h4000;
        run_vec(v, 4, 0, 1'b0);

        // Output backpressure for 10 cycles.
        run_vec(rand_vec(), 4, 10, 1'b0);

        // Short core latency: returns overlap issuing.
        run_vec(rand_vec(), 1, 2, 1'b0);

        // Reset after the second issue; stale results must not leak into the next vector.
        lat = 4;
        wait_idle();
        bus.a        = rand_vec();
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", dbg_state, 3'd0);
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_ex_in_valid", bus.ex_in_valid, 1'b0);
        check("midrst_busy", busy, 1'b1);
        run_vec(rand_vec(), 4, 0, 1'b0);

        // Randomized vectors, latencies and consumer stalls.
        for (int k = 0; k < 20; k++)
            run_vec(rand_vec(), $urandom_range(1, LAT), $urandom_range(0, 3), 1'b0);

`ifdef EXPV_TIMEOUT_EN
        // Core drops the third result: watchdog fires, partial vector delivered.
        drop3 = 1'b1;
        run_vec(rand_vec(), 4, 1, 1'b1);
        drop3 = 1'b0;
        @(negedge clk);
        check("err_sticky", err, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("err_cleared", err, 1'b0);
        run_vec(rand_vec(), 3, 0, 1'b0);
`endif

        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
